mult_sequencer: RTL

- Control unit that shares the 32-bit sequential Booth multiplier (start/fim handshake, 32-iteration latency) with the CPU datapath.
- Accepts MULT/MFHI/MFLO/MTHI/MTLO requests from the execute stage and owns the architectural HI/LO registers.
- Sequences the multiplier's start pulse and captures its hi/lo result.
- Stalls the requester while a multiply is in flight and recovers from a hung multiplier via a watchdog.

---
 rtl/mult_seq_pkg.sv | 20 ++
 rtl/mult_watchdog.sv | 26 ++
 rtl/mult_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared op codes, FSM encoding and defaults for the HI/LO multiply sequencer.
package mult_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MFHI = 3'd2;
    localparam logic [2:0] OP_MFLO = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ARM   = 2'd2,
        ST_BUSY  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_watchdog.sv
// Cycle counter that flags a multiply which has run for TIMEOUT cycles without finishing.
module mult_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count;

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Owns HI/LO and drives the shared sequential multiplier through start/fim with a watchdog.
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             req_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             error,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_abort,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo
);
    state_t           state, state_next;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             wd_clear, wd_enable, wd_expire;
    logic             abort_pulse;

    mult_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid && req_op == OP_MULT) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_ARM;
            ST_ARM:   state_next = ST_BUSY;
            ST_BUSY:  if (mul_done || wd_expire) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == ST_IDLE) && req_valid;
        busy        = (state != ST_IDLE);
        mul_start   = (state == ST_ISSUE);
        wd_clear    = (state == ST_ARM);
        wd_enable   = (state == ST_BUSY);
        abort_pulse = wd_expire && !mul_done;
        rd_data     = '0;
        if (req_ready) begin
            if (req_op == OP_MFHI) rd_data = hi_reg;
            if (req_op == OP_MFLO) rd_data = lo_reg;
        end
    end

    // A completing multiply wins over an expiring watchdog in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            error  <= 1'b0;
        end else begin
            if (req_ready) begin
                case (req_op)
                    OP_MULT: begin
                        mul_a <= rs_data;
                        mul_b <= rt_data;
                    end
                    OP_MTHI: hi_reg <= rs_data;
                    OP_MTLO: lo_reg <= rs_data;
                    default: ;
                endcase
            end
            if (state == ST_BUSY && mul_done) begin
                hi_reg <= mul_hi;
                lo_reg <= mul_lo;
            end
            if (abort_pulse) error <= 1'b1;
        end
    end

    assign mul_abort = !reset || abort_pulse;

endmodule
